icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc.sv | 132 +++++++++++++
 tb/tb_icache_assoc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hit path, single outstanding
// line fill with lowest-invalid / per-set round-robin victim selection.
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      cache_en,
    input  logic                      cache_st,
    input  logic                      flush,
    input  logic [31:0]               if_addr,
    output logic                      if_cache_hit,
    output logic [31:0]               if_hit_word,
    output logic                      mc_fc_ena,
    output logic [31:0]               mc_fc_addr,
    input  logic                      mc_fc_done,
    input  logic [32*LINE_WORDS-1:0]  mc_fc_line
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;
    typedef enum logic {IDLE, FETCH} state_t;

    state_t state, state_next;

    logic [WAYS-1:0][SETS-1:0]  valid;
    logic [SETS-1:0][PTR_W-1:0] rr;
    logic [TAG_W-1:0]           tag_mem  [WAYS][SETS];
    line_t                      data_mem [WAYS][SETS];

    logic [IDX_W-1:0]  idx, f_idx;
    logic [TAG_W-1:0]  tag, f_tag;
    logic [WOFF_W-1:0] woff;
    logic [WAYS-1:0]   way_hit;
    line_t             way_line [WAYS];
    line_t             hit_line;
    logic [PTR_W-1:0]  victim, rr_inc;
    logic              drop, issue, fill_done, install;
    logic              unused_bits;

    assign idx   = if_addr[OFF_W +: IDX_W];
    assign tag   = if_addr[31 -: TAG_W];
    assign woff  = if_addr[OFF_W-1:2];
    assign f_idx = mc_fc_addr[OFF_W +: IDX_W];
    assign f_tag = mc_fc_addr[31 -: TAG_W];
    assign unused_bits = ^if_addr[1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_hit[w]  = valid[w][idx] && (tag_mem[w][idx] == tag);
        assign way_line[w] = data_mem[w][idx];
    end

    // At most one way can match, so OR-ing the masked lines is a clean mux.
    always_comb begin
        hit_line = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_line = hit_line | way_line[w];
        if_cache_hit = |way_hit;
        if_hit_word  = hit_line[woff];
    end

    // Victim: lowest-numbered invalid way wins, otherwise the round-robin pointer.
    always_comb begin
        victim = rr[f_idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w][f_idx]) victim = PTR_W'(w);
        rr_inc = (WAYS == 1) ? '0 : rr[f_idx] + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cache_en && !cache_st && !flush && !if_cache_hit) state_next = FETCH;
            FETCH: if (mc_fc_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mc_fc_ena = (state == FETCH);
        issue     = (state == IDLE) && (state_next == FETCH);
        fill_done = (state == FETCH) && mc_fc_done;
        install   = !rst && rdy && fill_done && !drop && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_fc_addr <= '0;
            drop       <= 1'b0;
        end else if (rdy) begin
            if (issue) mc_fc_addr <= {if_addr[31:OFF_W], {OFF_W{1'b0}}};
            // A flush during the fetch makes the returning line stale.
            if (fill_done)                    drop <= 1'b0;
            else if (flush && state == FETCH) drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            rr    <= '0;
        end else if (rdy) begin
            if (flush) begin
                valid <= '0;
            end else if (install) begin
                valid[victim][f_idx] <= 1'b1;
                if (victim == rr[f_idx]) rr[f_idx] <= rr_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[victim][f_idx]  <= f_tag;
            data_mem[victim][f_idx] <= mc_fc_line;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: fetch-request scoreboard plus hit/word checks,
// with a second direct-mapped instance.
module tb_icache_assoc;

    logic         clk = 1'b0;
    logic         rst, rdy, cache_en, cache_st, flush, done;
    logic [31:0]  if_addr;
    logic         hit, ena;
    logic [31:0]  word, fa;
    logic [127:0] line;

    logic         en1, done1, hit1, ena1;
    logic [31:0]  addr1, word1, fa1;
    logic [127:0] line1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    icache_assoc #(.WAYS(2), .SETS(64), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .cache_en(cache_en), .cache_st(cache_st),
        .flush(flush), .if_addr(if_addr), .if_cache_hit(hit), .if_hit_word(word),
        .mc_fc_ena(ena), .mc_fc_addr(fa), .mc_fc_done(done), .mc_fc_line(line)
    );

    icache_assoc #(.WAYS(1), .SETS(64), .LINE_WORDS(4)) dut1 (
        .clk(clk), .rst(rst), .rdy(rdy), .cache_en(en1), .cache_st(cache_st),
        .flush(flush), .if_addr(addr1), .if_cache_hit(hit1), .if_hit_word(word1),
        .mc_fc_ena(ena1), .mc_fc_addr(fa1), .mc_fc_done(done1), .mc_fc_line(line1)
    );

    function automatic logic [127:0] mk(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] a, input logic exp_hit,
                        input logic [31:0] exp_word);
        if_addr = a;
        #1;
        chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        if (exp_hit) chk({tag, "_word"}, word, exp_word);
    endtask

    // Pop the oldest expected fetch address and compare with the issued request.
    task automatic req_check(input string tag);
        logic [31:0] e;
        chk({tag, "_ena"}, 32'(ena), 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_unexpected observed %h expected none", tag, fa);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, fa, e);
        end
    endtask

    task automatic issue(input string tag, input logic [31:0] a);
        if_addr  = a;
        cache_en = 1'b1;
        exp_q.push_back({a[31:4], 4'h0});
        tick();
        cache_en = 1'b0;
        req_check(tag);
    endtask

    task automatic finish_fill(input logic [31:0] b);
        done = 1'b1;
        line = mk(b);
        tick();
        done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; cache_en = 1'b0; cache_st = 1'b0; flush = 1'b0;
        done = 1'b0; if_addr = '0; line = '0;
        en1 = 1'b0; done1 = 1'b0; addr1 = '0; line1 = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_addr", fa, 32'h0);
        chk("rst_ptr", 32'(dut.rr[0]), 32'd0);
        look("rst_miss", 32'h1004, 1'b0, 32'h0);

        // basic miss, held request, fill, word select
        issue("first", 32'h1004);
        if_addr  = 32'h2000;
        cache_en = 1'b1;
        tick();
        cache_en = 1'b0;
        chk("hold_ena", 32'(ena), 32'd1);
        chk("hold_addr", fa, 32'h1000);
        done = 1'b1;
        line = mk(32'hD000_0000);
        look("no_bypass", 32'h1004, 1'b0, 32'h0);
        tick();
        done = 1'b0;
        chk("fill_ena", 32'(ena), 32'd0);
        look("w1", 32'h1004, 1'b1, 32'hD000_0001);
        look("w3", 32'h100C, 1'b1, 32'hD000_0003);

        // done pulse while idle is ignored
        finish_fill(32'h9900_0000);
        chk("idle_done_ena", 32'(ena), 32'd0);
        look("idle_done", 32'h1000, 1'b1, 32'hD000_0000);

        // flush, then two-way fill and round-robin eviction in set 0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        look("flushed", 32'h1000, 1'b0, 32'h0);
        issue("f0", 32'h0000);
        finish_fill(32'hB000_0000);
        issue("f4", 32'h0400);
        finish_fill(32'hB100_0000);
        look("a0", 32'h0000, 1'b1, 32'hB000_0000);
        look("a4", 32'h0404, 1'b1, 32'hB100_0001);
        chk("ptr_a", 32'(dut.rr[0]), 32'd0);
        issue("f8", 32'h0800);
        finish_fill(32'hB200_0000);
        look("evict0", 32'h0000, 1'b0, 32'h0);
        look("keep4", 32'h0408, 1'b1, 32'hB100_0002);
        look("new8", 32'h080C, 1'b1, 32'hB200_0003);
        chk("ptr_b", 32'(dut.rr[0]), 32'd1);

        // flush during fetch drops the returning line
        issue("d0", 32'h2000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        finish_fill(32'hC000_0000);
        chk("drop_ena", 32'(ena), 32'd0);
        look("drop_miss", 32'h2000, 1'b0, 32'h0);
        look("drop_fl", 32'h0400, 1'b0, 32'h0);
        issue("d1", 32'h2000);
        finish_fill(32'hC100_0000);
        look("refill", 32'h2004, 1'b1, 32'hC100_0001);

        // flush in the same cycle as done
        issue("s0", 32'h3000);
        flush = 1'b1;
        done  = 1'b1;
        line  = mk(32'hC200_0000);
        tick();
        flush = 1'b0;
        done  = 1'b0;
        chk("same_ena", 32'(ena), 32'd0);
        look("same_miss", 32'h3000, 1'b0, 32'h0);
        look("same_fl", 32'h2000, 1'b0, 32'h0);

        // stall blocks issue but not fill acceptance
        cache_st = 1'b1;
        cache_en = 1'b1;
        if_addr  = 32'h4000;
        tick();
        tick();
        chk("stall_noreq", 32'(ena), 32'd0);
        cache_en = 1'b0;
        cache_st = 1'b0;
        issue("st", 32'h4000);
        cache_st = 1'b1;
        cache_en = 1'b1;
        finish_fill(32'hE000_0000);
        chk("st_ena", 32'(ena), 32'd0);
        look("st_hit", 32'h4008, 1'b1, 32'hE000_0002);
        cache_en = 1'b0;
        cache_st = 1'b0;

        // rdy low freezes state and ignores done/flush
        issue("r", 32'h5000);
        rdy = 1'b0;
        finish_fill(32'hF000_0000);
        chk("rdy_ena", 32'(ena), 32'd1);
        look("rdy_miss", 32'h5000, 1'b0, 32'h0);
        rdy = 1'b1;
        finish_fill(32'hF000_0000);
        look("rdy_fill", 32'h5004, 1'b1, 32'hF000_0001);
        rdy   = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rdy   = 1'b1;
        look("rdy_noflush", 32'h5000, 1'b1, 32'hF000_0000);

        // reset during fetch abandons the request
        issue("x", 32'h6000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("xrst_ena", 32'(ena), 32'd0);
        chk("xrst_addr", fa, 32'h0);
        look("xrst_miss", 32'h5000, 1'b0, 32'h0);
        finish_fill(32'h6600_0000);
        chk("xrst_done_ena", 32'(ena), 32'd0);
        look("xrst_ign", 32'h6000, 1'b0, 32'h0);

        // direct-mapped instance
        addr1 = 32'h0000;
        en1   = 1'b1;
        tick();
        en1 = 1'b0;
        chk("dm0_ena", 32'(ena1), 32'd1);
        chk("dm0_addr", fa1, 32'h0000);
        done1 = 1'b1;
        line1 = mk(32'h7000_0000);
        tick();
        done1 = 1'b0;
        #1;
        chk("dm0_hit", 32'(hit1), 32'd1);
        chk("dm0_word", word1, 32'h7000_0000);
        addr1 = 32'h0400;
        en1   = 1'b1;
        tick();
        en1 = 1'b0;
        chk("dm4_ena", 32'(ena1), 32'd1);
        chk("dm4_addr", fa1, 32'h0400);
        done1 = 1'b1;
        line1 = mk(32'h7100_0000);
        tick();
        done1 = 1'b0;
        addr1 = 32'h0000;
        #1;
        chk("dm_evict", 32'(hit1), 32'd0);
        addr1 = 32'h0404;
        #1;
        chk("dm4_hit", 32'(hit1), 32'd1);
        chk("dm4_word", word1, 32'h7100_0001);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
